// File: rtl/dbi_rx_decoder.sv
// dbi_rx_decoder
// Receive-side Data Bus Inversion decoder. Each accepted beat is restored
// (inverted when its DBI flag is set) and queued, together with its last
// marker, in a small FIFO that feeds a valid/ready consumer. A two-state
// burst tracker and saturating statistics counters run alongside.
//
// Optional feature macro: DBI_CHECK_EN
//   When defined, every accepted beat is checked against the transmit-side
//   DC-balance rule (at most 4 ones when not inverted, at most 3 ones when
//   inverted). Violations set a sticky flag and bump a saturating counter.
//   When undefined, no ones-count logic exists and viol/viol_cnt are 0.
//
// Parameters:
//   DEPTH  FIFO depth in beats (power of two, >= 2)
//   CNT_W  width of the statistics counters
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready depends on FIFO state only
//   in_data, in_dbi       sampled bus byte and its inversion flag
//   in_last               burst end marker carried through with the beat
//   out_valid/out_ready   output handshake
//   out_data, out_last    decoded head-of-FIFO beat
//   clr                   synchronous clear of counters and sticky flags
//   in_burst              high while the burst tracker is inside a burst
//   inv_cnt, burst_cnt    saturating counts of inverted beats / burst ends
//   viol, viol_cnt        DC-rule violation flag and count

module dbi_rx_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_dbi,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             clr,
  output logic             in_burst,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] invCnt_q, invCnt_d;
  logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
  logic [8:0]       fifoMem_q [DEPTH];

  logic       full, empty, push, pop;
  logic [7:0] decoded;
  logic [8:0] headEntry;

  // Pointers carry one extra wrap bit: equal means empty, differing only
  // in the wrap bit means full.
  assign full  = (wrPtr_q == {~rdPtr_q[AW], rdPtr_q[AW-1:0]});
  assign empty = (wrPtr_q == rdPtr_q);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign decoded   = in_dbi ? ~in_data : in_data;

  // Storage is left unreset; the head is masked while empty so the outputs
  // read zero after reset and never expose a stale entry.
  assign headEntry = fifoMem_q[rdPtr_q[AW-1:0]];
  assign out_data  = empty ? 8'h00 : headEntry[7:0];
  assign out_last  = empty ? 1'b0  : headEntry[8];
  assign in_burst  = (state_q == BURST);
  assign inv_cnt   = invCnt_q;
  assign burst_cnt = burstCnt_q;

  // FIFO storage write: decoded byte plus last marker.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q[AW-1:0]] <= {in_last, decoded};
    end
  end

  // Next-state for pointers, burst tracker and counters. clr has priority
  // over any increment in the same cycle; FIFO and FSM ignore clr.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    state_d    = state_q;
    invCnt_d   = invCnt_q;
    burstCnt_d = burstCnt_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
      state_d = in_last ? IDLE : BURST;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (clr) begin
      invCnt_d   = '0;
      burstCnt_d = '0;
    end else if (push) begin
      if (in_dbi && invCnt_q != CNT_MAX) begin
        invCnt_d = invCnt_q + CNT_W'(1);
      end
      if (in_last && burstCnt_q != CNT_MAX) begin
        burstCnt_d = burstCnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      state_q    <= IDLE;
      invCnt_q   <= '0;
      burstCnt_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      state_q    <= state_d;
      invCnt_q   <= invCnt_d;
      burstCnt_q <= burstCnt_d;
    end
  end

`ifdef DBI_CHECK_EN
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] violCnt_q, violCnt_d;
  logic [3:0]       onesCount;
  logic             violBeat;

  // Ones count of the raw bus byte as it appeared on the wires.
  always_comb begin
    onesCount = 4'd0;
    for (int i = 0; i < 8; i++) begin
      onesCount = onesCount + {3'b000, in_data[i]};
    end
  end

  // An inverted beat was sent because the original had more than 4 ones,
  // so the wire byte must then hold at most 3.
  assign violBeat = push && (in_dbi ? (onesCount > 4'd3) : (onesCount > 4'd4));

  always_comb begin
    viol_d    = viol_q;
    violCnt_d = violCnt_q;
    if (clr) begin
      viol_d    = 1'b0;
      violCnt_d = '0;
    end else if (violBeat) begin
      viol_d = 1'b1;
      if (violCnt_q != CNT_MAX) begin
        violCnt_d = violCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_q    <= 1'b0;
      violCnt_q <= '0;
    end else begin
      viol_q    <= viol_d;
      violCnt_q <= violCnt_d;
    end
  end

  assign viol     = viol_q;
  assign viol_cnt = violCnt_q;
`else
  assign viol     = 1'b0;
  assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_dbi_rx_decoder.sv
// tb_dbi_rx_decoder
// Directed bench for dbi_rx_decoder. The counters are built 4 bits wide so
// saturation is reachable quickly. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.

module tb_dbi_rx_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_dbi = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       clr = 1'b0;
  logic       in_burst;
  logic [3:0] inv_cnt;
  logic [3:0] burst_cnt;
  logic       viol;
  logic [3:0] viol_cnt;

  int assertCount = 0;
  int failCount   = 0;

  dbi_rx_decoder #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dbi(in_dbi), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .clr(clr), .in_burst(in_burst), .inv_cnt(inv_cnt),
    .burst_cnt(burst_cnt), .viol(viol), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one beat for one clock; called and returns on a falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic dbi, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_dbi   = dbi;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] expData;

    // Reset values while reset is held
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_burst", in_burst, 0);
    checkOutput("rst_inv_cnt", inv_cnt, 0);
    checkOutput("rst_burst_cnt", burst_cnt, 0);
    checkOutput("rst_viol", viol, 0);
    checkOutput("rst_viol_cnt", viol_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic decode with the consumer always ready
    out_ready = 1'b1;
    applyStimulus(8'hF0, 1'b0, 1'b0);
    checkOutput("t1_b0_valid", out_valid, 1);
    checkOutput("t1_b0_data", out_data, 8'hF0);
    checkOutput("t1_b0_last", out_last, 0);
    checkOutput("t1_b0_burst", in_burst, 1);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    checkOutput("t1_b1_data", out_data, 8'hF0);
    checkOutput("t1_b1_last", out_last, 0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("t1_b2_data", out_data, 8'hFF);
    checkOutput("t1_b2_last", out_last, 1);
    checkOutput("t1_b2_burst", in_burst, 0);
    checkOutput("t1_inv_cnt", inv_cnt, 2);
    checkOutput("t1_burst_cnt", burst_cnt, 1);

    // Fill to DEPTH with the consumer stalled, then pop while full
    pulseClr();
    checkOutput("t2_empty", out_valid, 0);
    out_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1);
    checkOutput("t2_rdy1", in_ready, 1);
    applyStimulus(8'h22, 1'b0, 1'b1);
    checkOutput("t2_rdy2", in_ready, 1);
    applyStimulus(8'h33, 1'b0, 1'b1);
    checkOutput("t2_rdy3", in_ready, 1);
    applyStimulus(8'h44, 1'b0, 1'b1);
    checkOutput("t2_full_rdy", in_ready, 0);
    checkOutput("t2_full_head", out_data, 8'h11);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_dbi   = 1'b0;
    in_last  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("t2_rdy_after_pop", in_ready, 1);
    checkOutput("t2_head22", out_data, 8'h22);
    @(negedge clk);
    checkOutput("t2_head33", out_data, 8'h33);
    @(negedge clk);
    checkOutput("t2_head44", out_data, 8'h44);
    @(negedge clk);
    checkOutput("t2_drained", out_valid, 0);

    // Streaming at one beat per cycle
    for (int i = 0; i <= 64; i++) begin
      if (i > 0) begin
        expData = 8'(i - 1);
        if (expData[0]) expData = ~expData;
        checkOutput("t3_valid", out_valid, 1);
        checkOutput("t3_data", out_data, expData);
      end
      checkOutput("t3_ready", in_ready, 1);
      if (i < 64) begin
        in_valid = 1'b1;
        in_data  = 8'(i);
        in_dbi   = in_data[0];
        in_last  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("t3_drained", out_valid, 0);

    // Four-beat burst followed by a single-beat burst
    pulseClr();
    checkOutput("t4_idle", in_burst, 0);
    applyStimulus(8'hA0, 1'b0, 1'b0);
    checkOutput("t4_burst1", in_burst, 1);
    applyStimulus(8'hA1, 1'b0, 1'b0);
    checkOutput("t4_burst2", in_burst, 1);
    applyStimulus(8'hA2, 1'b0, 1'b0);
    checkOutput("t4_burst3", in_burst, 1);
    checkOutput("t4_data3", out_data, 8'hA2);
    applyStimulus(8'hA3, 1'b0, 1'b1);
    checkOutput("t4_burst4", in_burst, 0);
    applyStimulus(8'hB0, 1'b0, 1'b1);
    checkOutput("t4_single", in_burst, 0);
    checkOutput("t4_single_last", out_last, 1);
    checkOutput("t4_burst_cnt", burst_cnt, 2);

    // DC-balance rule: two legal beats, then two violating ones
    pulseClr();
    applyStimulus(8'h0F, 1'b0, 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("t5_legal_viol", viol, 0);
    checkOutput("t5_legal_data", out_data, 8'hF8);
    applyStimulus(8'h1F, 1'b0, 1'b1);
    checkOutput("t5_data1F", out_data, 8'h1F);
    applyStimulus(8'h0F, 1'b1, 1'b1);
    checkOutput("t5_dataF0", out_data, 8'hF0);
    checkOutput("t5_inv_cnt", inv_cnt, 2);
`ifdef DBI_CHECK_EN
    checkOutput("t5_viol", viol, 1);
    checkOutput("t5_viol_cnt", viol_cnt, 2);
`else
    checkOutput("t5_viol_off", viol, 0);
    checkOutput("t5_viol_cnt_off", viol_cnt, 0);
`endif
    pulseClr();
    checkOutput("t5_clr_viol", viol, 0);
    checkOutput("t5_clr_viol_cnt", viol_cnt, 0);
    checkOutput("t5_clr_inv_cnt", inv_cnt, 0);

    // Saturation of the 4-bit counters, clr priority, then reset mid-burst
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b1);
      if (i == 14) checkOutput("t6_inv15", inv_cnt, 4'hF);
    end
    checkOutput("t6_inv_sat", inv_cnt, 4'hF);
    checkOutput("t6_burst_sat", burst_cnt, 4'hF);
    clr = 1'b1;
    applyStimulus(8'h01, 1'b1, 1'b1);
    clr = 1'b0;
    checkOutput("t6_clr_wins", inv_cnt, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h80, 1'b1, 1'b1);
    out_ready = 1'b0;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    checkOutput("t6_mid_burst", in_burst, 1);
    checkOutput("t6_mid_valid", out_valid, 1);
    checkOutput("t6_mid_inv", inv_cnt, 4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_burst", in_burst, 0);
    checkOutput("t6_rst_inv", inv_cnt, 0);
    checkOutput("t6_rst_bcnt", burst_cnt, 0);
    checkOutput("t6_rst_ready", in_ready, 1);
    checkOutput("t6_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_post_valid", out_valid, 0);
    checkOutput("t6_post_burst", in_burst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
